// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB command master.
package apb_pkg;
  localparam int ADDR_W_DEF  = 7;
  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;
endpackage

// File: rtl/apb_master_if.sv
// Command push, APB request/completion and response signals of apb_master.
interface apb_master_if import apb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              psel;
  logic              enbl;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              is_apb;

  logic              pready;
  logic              slerr;
  logic [DATA_W-1:0] prdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, slerr, prdata,
    output cmd_ready, psel, enbl, pwrite, paddr, pwdata, is_apb,
           rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, slerr, prdata,
    input  cmd_ready, psel, enbl, pwrite, paddr, pwdata, is_apb,
           rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/apb_master_cmd_fifo.sv
// Command FIFO: registered occupancy, head visible combinationally, DEPTH a power of 2 (>= 2).
module cmd_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/apb_master.sv
// APB master: queues {write, addr, wdata} commands and runs them as APB transfers
// with a per-transfer wait-state timeout and a one-cycle response pulse.
module apb_master import apb_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         res,
  apb_master_if.master bus
);
  localparam int FW    = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e        state_q;
  logic [CNT_W-1:0]  wait_q;
  logic              psel_q, enbl_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic [FW-1:0]     head;
  logic              full, empty, push, pop;

  assign push          = bus.cmd_valid && !full;
  assign bus.cmd_ready = !full;

  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      IDLE:    pop = !empty;
      ACCESS:  pop = bus.pready && !empty;
      default: pop = 1'b0;
    endcase
  end

  cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .res     (res),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      enbl_q        <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            {pwrite_q, paddr_q, pwdata_q} <= head;
            psel_q  <= 1'b1;
            enbl_q  <= 1'b0;
            wait_q  <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          enbl_q  <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          // pready wins over the timeout when both land in the same cycle.
          if (bus.pready) begin
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= bus.slerr;
            rsp_timeout_q <= 1'b0;
            if (!pwrite_q) rsp_rdata_q <= bus.prdata;
            if (!empty) begin
              {pwrite_q, paddr_q, pwdata_q} <= head;
              enbl_q  <= 1'b0;
              wait_q  <= '0;
              state_q <= SETUP;
            end else begin
              psel_q  <= 1'b0;
              enbl_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
            psel_q        <= 1'b0;
            enbl_q        <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.psel        = psel_q;
  assign bus.enbl        = enbl_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.is_apb      = (state_q != IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: table of single transfers plus back-to-back and reset sequences.
module tb_apb_master;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .DEPTH   (4),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic          serr;
    logic [DW-1:0] rdata_in;
    int            exp_acc;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic check_idle(input string p);
    chk({p, " psel"},        64'(bus.psel), 64'(0));
    chk({p, " enbl"},        64'(bus.enbl), 64'(0));
    chk({p, " pwrite"},      64'(bus.pwrite), 64'(0));
    chk({p, " paddr"},       64'(bus.paddr), 64'(0));
    chk({p, " pwdata"},      64'(bus.pwdata), 64'(0));
    chk({p, " is_apb"},      64'(bus.is_apb), 64'(0));
    chk({p, " rsp_valid"},   64'(bus.rsp_valid), 64'(0));
    chk({p, " rsp_err"},     64'(bus.rsp_err), 64'(0));
    chk({p, " rsp_timeout"}, 64'(bus.rsp_timeout), 64'(0));
    chk({p, " rsp_rdata"},   64'(bus.rsp_rdata), 64'(0));
    chk({p, " cmd_ready"},   64'(bus.cmd_ready), 64'(1));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   acc, enb;
    logic got, addr_ok;
    string p;
    p = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    chk({p, " cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    @(posedge clk); #1;                       // edge k: accepted
    bus.cmd_valid = 1'b0;
    chk({p, " psel@k"}, 64'(bus.psel), 64'(0));
    @(posedge clk); #1;                       // edge k+1: SETUP
    chk({p, " psel@k+1"}, 64'(bus.psel), 64'(1));
    chk({p, " enbl@k+1"}, 64'(bus.enbl), 64'(0));
    chk({p, " paddr"},    64'(bus.paddr), 64'(v.addr));
    chk({p, " pwrite"},   64'(bus.pwrite), 64'(v.wr));
    chk({p, " pwdata"},   64'(bus.pwdata), 64'(v.wdata));
    chk({p, " is_apb"},   64'(bus.is_apb), 64'(1));
    bus.pready = 1'b1;                        // must be ignored in SETUP
    bus.slerr  = 1'b1;
    @(posedge clk); #1;                       // edge k+2: ACCESS
    chk({p, " enbl@k+2"}, 64'(bus.enbl), 64'(1));
    chk({p, " psel@k+2"}, 64'(bus.psel), 64'(1));
    chk({p, " no rsp in SETUP"}, 64'(bus.rsp_valid), 64'(0));
    acc = 0; enb = 0; got = 1'b0; addr_ok = 1'b1;
    while (!got && acc < 40) begin
      if (bus.enbl) enb++;
      if (bus.paddr !== v.addr) addr_ok = 1'b0;
      bus.pready = (acc >= v.waits);
      bus.slerr  = v.serr;
      bus.prdata = v.rdata_in;
      @(posedge clk); #1;
      acc++;
      got = bus.rsp_valid;
    end
    bus.pready = 1'b0;
    bus.slerr  = 1'b0;
    bus.prdata = '0;
    chk({p, " rsp_valid seen"}, 64'(got), 64'(1));
    chk({p, " access cycles"},  64'(acc), 64'(v.exp_acc));
    chk({p, " enbl cycles"},    64'(enb), 64'(v.exp_acc));
    chk({p, " paddr stable"},   64'(addr_ok), 64'(1));
    chk({p, " rsp_rdata"},      64'(bus.rsp_rdata), 64'(v.exp_rdata));
    chk({p, " rsp_err"},        64'(bus.rsp_err), 64'(v.exp_err));
    chk({p, " rsp_timeout"},    64'(bus.rsp_timeout), 64'(v.exp_to));
    chk({p, " psel after"},     64'(bus.psel), 64'(0));
    chk({p, " enbl after"},     64'(bus.enbl), 64'(0));
    chk({p, " is_apb after"},   64'(bus.is_apb), 64'(0));
    @(posedge clk); #1;
    chk({p, " rsp_valid pulse"}, 64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required the test to complete");
    $fatal(1);
  end

  initial begin
    int n_rsp, n_setup, psel_drop, psel_hi;
    logic [AW-1:0] seen [4];

    //                wr    addr   wdata         waits serr prdata_in     acc rdata         err   to
    vecs[0] = '{1'b1, 7'h05, 32'hDEADBEEF, 0,  1'b0, 32'hFFFF0000, 1,  32'h00000000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 7'h10, 32'h00000000, 3,  1'b0, 32'h12345678, 4,  32'h12345678, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 7'h7F, 32'hAAAA5555, 1,  1'b0, 32'h11111111, 2,  32'h12345678, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 7'h22, 32'h00000000, 0,  1'b1, 32'hCAFEF00D, 1,  32'hCAFEF00D, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 7'h33, 32'h00000000, 40, 1'b0, 32'h99999999, TO, 32'hCAFEF00D, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 7'h01, 32'h00000000, 14, 1'b0, 32'h0BADC0DE, TO, 32'h0BADC0DE, 1'b0, 1'b0};

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.pready = 1'b0; bus.slerr = 1'b0; bus.prdata = '0;

    #2 res = 1'b0;
    #1 check_idle("reset");
    repeat (3) @(posedge clk);
    #1 res = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Back-to-back: a stalled lead read lets four writes fill the FIFO.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 7'h40; bus.cmd_wdata = '0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("b2b lead in ACCESS", 64'(bus.enbl), 64'(1));
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
      bus.cmd_addr  = AW'(i); bus.cmd_wdata = 32'h100 + 32'(i);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    chk("b2b cmd_ready full", 64'(bus.cmd_ready), 64'(0));
    bus.pready = 1'b1; bus.prdata = 32'h5A5A5A5A;
    n_rsp = 0; n_setup = 0; psel_drop = 0;
    for (int c = 0; c < 40 && n_rsp < 5; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) n_rsp++;
      if (n_rsp < 5 && !bus.psel) psel_drop++;
      if (bus.psel && !bus.enbl) begin
        if (n_setup < 4) seen[n_setup] = bus.paddr;
        n_setup++;
      end
    end
    bus.pready = 1'b0; bus.prdata = '0;
    chk("b2b responses", 64'(n_rsp), 64'(5));
    chk("b2b psel drops", 64'(psel_drop), 64'(0));
    chk("b2b setups", 64'(n_setup), 64'(4));
    for (int i = 0; i < 4; i++) chk($sformatf("b2b order %0d", i), 64'(seen[i]), 64'(i));
    chk("b2b rdata from lead read", 64'(bus.rsp_rdata), 64'(32'h5A5A5A5A));
    chk("b2b psel end", 64'(bus.psel), 64'(0));
    chk("b2b cmd_ready end", 64'(bus.cmd_ready), 64'(1));

    // Reset during ACCESS with two commands still queued.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 7'h11; bus.cmd_wdata = 32'h1;
    @(posedge clk); #1;
    bus.cmd_addr = 7'h12;
    @(posedge clk); #1;
    bus.cmd_addr = 7'h13;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("rst pre ACCESS", 64'(bus.enbl), 64'(1));
    @(posedge clk); #2;
    res = 1'b0;
    #1 check_idle("mid-reset");
    repeat (2) @(posedge clk);
    #1 res = 1'b1;
    bus.pready = 1'b1;
    n_rsp = 0; psel_hi = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) n_rsp++;
      if (bus.psel) psel_hi++;
    end
    bus.pready = 1'b0;
    chk("post-reset rsp_valid count", 64'(n_rsp), 64'(0));
    chk("post-reset psel count", 64'(psel_hi), 64'(0));
    chk("post-reset cmd_ready", 64'(bus.cmd_ready), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
